k12a_lcd_responder: RTL

// - Synthesizable HD44780-style character LCD responder: the device end of the lcd_rs/lcd_rw/lcd_en/lcd_data bus that the k12a I/O block drives.
// - Decodes a subset of the command set, holds display RAM (DDRAM), the address counter and the busy flag, and answers status/data reads.
// - Used as the on-board LCD stand-in for simulation and FPGA builds; a debug read port exposes DDRAM contents.

---
 rtl/k12a_lcd_responder.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/k12a_lcd_responder.sv
// k12a_lcd_responder
// HD44780-style character LCD responder. It is the device end of the
// lcd_rs/lcd_rw/lcd_en/lcd_data bus that the k12a I/O block drives. It holds
// display RAM (DDRAM), the address counter and the busy flag, decodes a subset
// of the instruction set, and answers status and data reads.
//
// Ports
//   sys_clock      in   1       sole clock, rising edge
//   reset          in   1       asynchronous, active-high
//   lcd_rs         in   1       0 = instruction/status, 1 = data
//   lcd_rw         in   1       0 = write to responder, 1 = read from responder
//   lcd_en         in   1       transfer strobe, completes on its falling edge
//   lcd_data_in    in   8       bus value driven by the initiator
//   lcd_data_out   out  8       read data, valid while lcd_data_oe = 1
//   lcd_data_oe    out  1       responder drives the bus
//   busy           out  1       busy flag (BF)
//   cursor_addr    out  ADDR_W  address counter
//   display_on     out  1       display-control D bit
//   dbg_addr       in   ADDR_W  debug DDRAM read address
//   dbg_char       out  8       ddram[dbg_addr], combinational
//   protocol_error out  1       sticky, only with K12A_LCD_BUSY_CHECK_EN
//
// Build option
//   K12A_LCD_BUSY_CHECK_EN : when defined, write strobes seen while busy are
//   discarded and flagged on protocol_error. When undefined, busy is only
//   reported and a write during CLEAR/BUSY executes and restarts the FSM.

module k12a_lcd_responder #(
    parameter int  DEPTH       = 32,
    parameter int  BUSY_CYCLES = 40,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic              sys_clock,
    input  logic              reset,
    input  logic              lcd_rs,
    input  logic              lcd_rw,
    input  logic              lcd_en,
    input  logic [7:0]        lcd_data_in,
    output logic [7:0]        lcd_data_out,
    output logic              lcd_data_oe,
    output logic              busy,
    output logic [ADDR_W-1:0] cursor_addr,
    output logic              display_on,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_char
`ifdef K12A_LCD_BUSY_CHECK_EN
    ,
    output logic              protocol_error
`endif
);

    localparam int CNT_W = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_BUSY
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d;
    logic              display_q, display_d;
    logic              inc_q, inc_d;
    logic              oe_q, oe_d;
    logic [7:0]        out_q, out_d;

    // Bus sampling registers, loaded every cycle.
    logic              en_q, rs_q, rw_q;
    logic [7:0]        data_q;

    logic [7:0]        ddram_q [DEPTH];
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;

    logic              strobe, wr_strobe, rd_strobe, wr_accept;
    logic [ADDR_W-1:0] cursor_step;
    logic [7:0]        status_word;

`ifdef K12A_LCD_BUSY_CHECK_EN
    logic              perr_q, perr_d;
`endif

    // A transfer completes on the cycle after the last high cycle of lcd_en,
    // so the latched rs/rw/data are those of that last high cycle.
    assign strobe      = en_q & ~lcd_en;
    assign wr_strobe   = strobe & ~rw_q;
    assign rd_strobe   = strobe & rw_q & rs_q;
    assign cursor_step = inc_q ? (cursor_q + ADDR_W'(1)) : (cursor_q - ADDR_W'(1));
    assign status_word = {busy, {(7 - ADDR_W){1'b0}}, cursor_q};

`ifdef K12A_LCD_BUSY_CHECK_EN
    assign wr_accept   = wr_strobe & ~busy;
`else
    assign wr_accept   = wr_strobe;
`endif

    // State register: FSM, address counter, mode bits, read port and bus
    // sampling, all cleared asynchronously.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            cursor_q  <= '0;
            display_q <= 1'b0;
            inc_q     <= 1'b1;
            oe_q      <= 1'b0;
            out_q     <= 8'h00;
            en_q      <= 1'b0;
            rs_q      <= 1'b0;
            rw_q      <= 1'b0;
            data_q    <= 8'h00;
`ifdef K12A_LCD_BUSY_CHECK_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cursor_q  <= cursor_d;
            display_q <= display_d;
            inc_q     <= inc_d;
            oe_q      <= oe_d;
            out_q     <= out_d;
            en_q      <= lcd_en;
            rs_q      <= lcd_rs;
            rw_q      <= lcd_rw;
            data_q    <= lcd_data_in;
`ifdef K12A_LCD_BUSY_CHECK_EN
            perr_q    <= perr_d;
`endif
        end
    end

    // DDRAM has no reset. While reset is held the FSM sits in CLEAR and may
    // rewrite location 0 with a space; the CLEAR that follows reset overwrites
    // every location anyway, so this is never visible.
    always_ff @(posedge sys_clock) begin
        if (ram_we) begin
            ddram_q[ram_waddr] <= ram_wdata;
        end
    end

    // Next-state logic. The FSM's own progress is computed first; an accepted
    // write strobe then overrides it, which is how a write during CLEAR/BUSY
    // aborts and restarts the operation when busy is not enforced.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cursor_d  = cursor_q;
        display_d = display_q;
        inc_d     = inc_q;
        oe_d      = lcd_en & lcd_rw;
        out_d     = out_q;
        ram_we    = 1'b0;
        ram_waddr = cursor_q;
        ram_wdata = 8'h20;
`ifdef K12A_LCD_BUSY_CHECK_EN
        perr_d    = perr_q | (wr_strobe & busy);
`endif

        // Read data is captured every cycle the initiator holds a read, so
        // the last captured value stays valid one cycle after lcd_en falls.
        if (lcd_en && lcd_rw) begin
            out_d = lcd_rs ? ddram_q[cursor_q] : status_word;
        end

        case (state_q)
            ST_IDLE: begin
            end
            ST_CLEAR: begin
                ram_we = 1'b1;
                if (cursor_q == ADDR_W'(DEPTH - 1)) begin
                    cursor_d = '0;
                    cnt_d    = CNT_W'(BUSY_CYCLES - 1);
                    state_d  = ST_BUSY;
                end else begin
                    cursor_d = cursor_q + ADDR_W'(1);
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        if (wr_accept) begin
            ram_we  = 1'b0;
            state_d = ST_BUSY;
            cnt_d   = CNT_W'(BUSY_CYCLES - 1);
            if (rs_q) begin
                ram_we    = 1'b1;
                ram_wdata = data_q;
                cursor_d  = cursor_step;
            end else begin
                casez (data_q)
                    8'b1???????: cursor_d  = data_q[ADDR_W-1:0];
                    8'b00001???: display_d = data_q[2];
                    8'b000001??: inc_d     = data_q[1];
                    8'b0000001?: cursor_d  = '0;
                    8'b00000001: begin
                        cursor_d = '0;
                        state_d  = ST_CLEAR;
                    end
                    default: begin
                    end
                endcase
            end
        end

        // Data reads advance the address counter regardless of busy.
        if (rd_strobe) begin
            cursor_d = cursor_step;
        end
    end

    // Outputs.
    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    assign lcd_data_out = out_q;
    assign lcd_data_oe  = oe_q;
    assign cursor_addr  = cursor_q;
    assign display_on   = display_q;
    assign dbg_char     = ddram_q[dbg_addr];
`ifdef K12A_LCD_BUSY_CHECK_EN
    assign protocol_error = perr_q;
`endif

endmodule
